// File: rtl/bp_fe_pc_gen_pipe.sv
// Fetch PC generator feeding a fixed-latency I$/ITLB pipeline, with redirect, override and replay.
// Optional return address stack: define BP_FE_PC_GEN_RAS_EN to build it.
module bp_fe_pc_gen_pipe #(
  parameter int vaddr_width_p = 39,
  parameter int stages_p      = 2,
  parameter int fetch_bytes_p = 4,
  parameter int ras_els_p     = 8,
  parameter logic [vaddr_width_p-1:0] boot_pc_p = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] redirect_pc_i,
  output logic                     fetch_v_o,
  output logic [vaddr_width_p-1:0] fetch_pc_o,
  input  logic                     fetch_ready_i,
  output logic                     poison_o,
  input  logic                     resp_v_i,
  input  logic                     resp_miss_i,
  input  logic                     resp_taken_i,
  input  logic                     resp_call_i,
  input  logic                     resp_ret_i,
  input  logic [vaddr_width_p-1:0] resp_tgt_i,
  input  logic                     queue_ready_i,
  output logic                     instr_v_o,
  output logic [vaddr_width_p-1:0] instr_pc_o
);
  typedef logic [vaddr_width_p-1:0] vaddr_t;
  typedef enum logic [1:0] {e_wait, e_stall, e_run} state_e;

  function automatic vaddr_t pc_inc(input vaddr_t pc);
    return pc + vaddr_t'(fetch_bytes_p);
  endfunction

  state_e              state_q, state_d;
  vaddr_t              resume_pc_q, resume_pc_d;
  vaddr_t              last_pc_q;
  logic [stages_p-1:0] v_q, v_d;
  vaddr_t              pc_q [stages_p];

  logic   tail_v, replay, override, fire, retire, ret_pred;
  vaddr_t tail_pc, ovr_tgt, ras_top;

  assign tail_v   = v_q[stages_p-1];
  assign tail_pc  = pc_q[stages_p-1];
  assign replay   = tail_v & (resp_miss_i | ~queue_ready_i);
  assign override = tail_v & resp_v_i & ~replay & ~redirect_v_i & (resp_taken_i | ret_pred);
  assign ovr_tgt  = resp_taken_i ? resp_tgt_i : ras_top;
  assign retire   = tail_v & resp_v_i & ~resp_miss_i & queue_ready_i & ~redirect_v_i;

  assign fetch_v_o  = ((state_q != e_wait) & queue_ready_i & ~replay) | redirect_v_i;
  assign fire       = fetch_v_o & fetch_ready_i;
  assign poison_o   = redirect_v_i | replay | override;
  assign instr_v_o  = retire;
  assign instr_pc_o = tail_pc;

  always_comb begin
    fetch_pc_o = pc_inc(last_pc_q);
    if (redirect_v_i)          fetch_pc_o = redirect_pc_i;
    else if (state_q != e_run) fetch_pc_o = resume_pc_q;
    else if (replay)           fetch_pc_o = tail_pc;
    else if (override)         fetch_pc_o = ovr_tgt;
  end

  // A redirect target that could not issue this cycle is parked in resume_pc until it fires
  always_comb begin
    state_d     = state_q;
    resume_pc_d = resume_pc_q;
    if (redirect_v_i) begin
      state_d     = fire ? e_run : e_stall;
      resume_pc_d = redirect_pc_i;
    end else begin
      case (state_q)
        e_stall: if (fire) state_d = e_run;
        e_run: begin
          if (replay) begin
            state_d     = e_stall;
            resume_pc_d = tail_pc;
          end else if (override & ~fire) begin
            state_d     = e_stall;
            resume_pc_d = ovr_tgt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    v_d    = '0;
    v_d[0] = fire;
    for (int i = 1; i < stages_p; i++)
      v_d[i] = v_q[i-1] & ~(redirect_v_i | replay | override);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_wait;
      v_q         <= '0;
      resume_pc_q <= boot_pc_p;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      resume_pc_q <= resume_pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fire) begin
      pc_q[0]   <= fetch_pc_o;
      last_pc_q <= fetch_pc_o;
    end
    for (int i = 1; i < stages_p; i++)
      pc_q[i] <= pc_q[i-1];
  end

`ifdef BP_FE_PC_GEN_RAS_EN
  localparam int ras_ptr_w = $clog2(ras_els_p);
  typedef logic [ras_ptr_w-1:0] ras_ptr_t;
  localparam logic [ras_ptr_w:0] ras_full = (ras_ptr_w+1)'(ras_els_p);

  vaddr_t             ras_mem_q [ras_els_p];
  ras_ptr_t           ras_ptr_q, ras_wr_idx;
  logic [ras_ptr_w:0] ras_cnt_q;
  logic               ras_push, ras_pop;

  assign ret_pred   = resp_ret_i & (ras_cnt_q != '0);
  assign ras_top    = ras_mem_q[ras_ptr_q];
  assign ras_pop    = retire & ret_pred;
  assign ras_push   = retire & resp_call_i;
  // Pop-then-push lands on the same slot, replacing the popped top in place
  assign ras_wr_idx = ras_pop ? ras_ptr_q : ras_ptr_q + 1'b1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (ras_push & ~ras_pop) begin
      ras_ptr_q <= ras_ptr_q + 1'b1;
      if (ras_cnt_q != ras_full) ras_cnt_q <= ras_cnt_q + 1'b1;
    end else if (ras_pop & ~ras_push) begin
      ras_ptr_q <= ras_ptr_q - 1'b1;
      ras_cnt_q <= ras_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ras_push) ras_mem_q[ras_wr_idx] <= pc_inc(tail_pc);
  end
`else
  logic unused_ras;
  assign ret_pred   = 1'b0;
  assign ras_top    = '0;
  assign unused_ras = &{1'b0, resp_call_i, resp_ret_i};
`endif

endmodule

// File: tb/tb_bp_fe_pc_gen_pipe.sv
// Bench for bp_fe_pc_gen_pipe: directed vector table plus random traffic against an in-flight-list model.
module tb_bp_fe_pc_gen_pipe;
  localparam int VA     = 39;
  localparam int STAGES = 2;
  localparam int FB     = 4;
  localparam int RAS_N  = 2;
`ifdef BP_FE_PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  typedef logic [VA-1:0] va_t;

  logic clk = 1'b0;
  logic reset_n;
  logic redirect_v, fetch_ready, resp_v, resp_miss, resp_taken, resp_call, resp_ret, queue_ready;
  va_t  redirect_pc, resp_tgt;
  logic fetch_v, poison, instr_v;
  va_t  fetch_pc, instr_pc;

  always #5 clk = ~clk;

  bp_fe_pc_gen_pipe #(
    .vaddr_width_p(VA), .stages_p(STAGES), .fetch_bytes_p(FB),
    .ras_els_p(RAS_N), .boot_pc_p(va_t'(0))
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .redirect_v_i(redirect_v), .redirect_pc_i(redirect_pc),
    .fetch_v_o(fetch_v), .fetch_pc_o(fetch_pc), .fetch_ready_i(fetch_ready),
    .poison_o(poison),
    .resp_v_i(resp_v), .resp_miss_i(resp_miss), .resp_taken_i(resp_taken),
    .resp_call_i(resp_call), .resp_ret_i(resp_ret), .resp_tgt_i(resp_tgt),
    .queue_ready_i(queue_ready),
    .instr_v_o(instr_v), .instr_pc_o(instr_pc)
  );

  typedef struct {
    bit redir; va_t rpc; bit fr; bit rv; bit miss; bit tk; bit cl; bit rt; va_t tgt; bit qr;
  } in_t;
  typedef struct { bit fv; va_t fpc; bit iv; va_t ipc; bit pz; } out_t;
  typedef struct { in_t i; out_t o; } vec_t;
  typedef struct { va_t pc; int age; } fl_t;

  int checks = 0;
  int errors = 0;

  // Model: list of in-flight PCs with their age, a pending target, and a bounded return stack
  fl_t infl[$];
  va_t m_ras[$];
  bit  m_started, m_have_res;
  va_t m_res, m_next;

  function automatic vec_t mk(bit redir, va_t rpc, bit fr, bit rv, bit miss, bit tk, bit cl, bit rt,
                              va_t tgt, bit qr, bit fv, va_t fpc, bit iv, va_t ipc, bit pz);
    vec_t v;
    v.i.redir = redir; v.i.rpc = rpc; v.i.fr = fr; v.i.rv = rv; v.i.miss = miss;
    v.i.tk = tk; v.i.cl = cl; v.i.rt = rt; v.i.tgt = tgt; v.i.qr = qr;
    v.o.fv = fv; v.o.fpc = fpc; v.o.iv = iv; v.o.ipc = ipc; v.o.pz = pz;
    return v;
  endfunction

  function automatic vec_t run_row(va_t fpc, bit iv, va_t ipc);
    return mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, fpc, iv, ipc, 0);
  endfunction

  function automatic vec_t redir_row(va_t pc);
    return mk(1, pc, 1, 1, 0, 0, 0, 0, 0, 1, 1, pc, 0, 0, 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    infl.delete();
    m_ras.delete();
    m_started  = 1'b0;
    m_have_res = 1'b1;
    m_res      = '0;
    m_next     = '0;
  endtask

  task automatic cmp_out(input string tag, input out_t e);
    chk({tag, " fetch_v"}, 64'(fetch_v), 64'(e.fv));
    if (e.fv) chk({tag, " fetch_pc"}, 64'(fetch_pc), 64'(e.fpc));
    chk({tag, " instr_v"}, 64'(instr_v), 64'(e.iv));
    if (e.iv) chk({tag, " instr_pc"}, 64'(instr_pc), 64'(e.ipc));
    chk({tag, " poison"}, 64'(poison), 64'(e.pz));
  endtask

  task automatic cyc(input in_t x, input bit use_tbl, input out_t t, input string tag);
    out_t m;
    bit   tv, replay, retp, ovr, fire;
    va_t  tpc, otgt;
    fl_t  nq[$];
    fl_t  e;
    @(negedge clk);
    redirect_v = x.redir; redirect_pc = x.rpc; fetch_ready = x.fr; resp_v = x.rv;
    resp_miss = x.miss; resp_taken = x.tk; resp_call = x.cl; resp_ret = x.rt;
    resp_tgt = x.tgt; queue_ready = x.qr;
    #1;
    tv = 1'b0; tpc = '0;
    foreach (infl[k]) if (infl[k].age == STAGES-1) begin tv = 1'b1; tpc = infl[k].pc; end
    replay = tv && (x.miss || !x.qr);
    retp   = RAS_EN && x.rt && (m_ras.size() > 0);
    ovr    = tv && x.rv && !replay && !x.redir && (x.tk || retp);
    otgt   = x.tk ? x.tgt : ((m_ras.size() > 0) ? m_ras[$] : va_t'(0));
    m.fv   = (m_started && x.qr && !replay) || x.redir;
    if (x.redir)                       m.fpc = x.rpc;
    else if (!m_started || m_have_res) m.fpc = m_res;
    else if (replay)                   m.fpc = tpc;
    else if (ovr)                      m.fpc = otgt;
    else                               m.fpc = m_next;
    m.iv  = tv && x.rv && !x.miss && x.qr && !x.redir;
    m.ipc = tpc;
    m.pz  = x.redir || replay || ovr;
    cmp_out({tag, " model"}, m);
    if (use_tbl) cmp_out({tag, " table"}, t);
    fire = m.fv && x.fr;
    if (RAS_EN && m.iv) begin
      if (retp) void'(m_ras.pop_back());
      if (x.cl) begin
        m_ras.push_back(tpc + va_t'(FB));
        if (m_ras.size() > RAS_N) void'(m_ras.pop_front());
      end
    end
    foreach (infl[k]) begin
      e = infl[k];
      if (!(x.redir || replay) && !(ovr && e.age != STAGES-1)) begin
        e.age++;
        if (e.age < STAGES) nq.push_back(e);
      end
    end
    infl = nq;
    if (fire) begin e.pc = m.fpc; e.age = 0; infl.push_back(e); end
    if (x.redir) begin
      m_started = 1'b1; m_have_res = !fire; m_res = x.rpc;
    end else if (m_started) begin
      if (m_have_res) begin
        if (fire) m_have_res = 1'b0;
      end else if (replay) begin
        m_have_res = 1'b1; m_res = tpc;
      end else if (ovr && !fire) begin
        m_have_res = 1'b1; m_res = otgt;
      end
    end
    if (fire) m_next = m.fpc + va_t'(FB);
  endtask

  initial begin
    vec_t tbl[$];
    out_t none;
    in_t  x;
    none = '{fv: 0, fpc: 0, iv: 0, ipc: 0, pz: 0};
    reset_n = 1'b0;
    redirect_v = 0; redirect_pc = '0; fetch_ready = 1; resp_v = 1; resp_miss = 1;
    resp_taken = 0; resp_call = 0; resp_ret = 0; resp_tgt = '0; queue_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset fetch_v", 64'(fetch_v), 64'(0));
    chk("reset instr_v", 64'(instr_v), 64'(0));
    chk("reset poison", 64'(poison), 64'(0));
    @(negedge clk);
    resp_miss = 0;
    reset_n = 1'b1;
    m_reset();

    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(redir_row('h8000_0000));
    tbl.push_back(run_row('h8000_0004, 0, 0));
    tbl.push_back(run_row('h8000_0008, 1, 'h8000_0000));
    tbl.push_back(run_row('h8000_000C, 1, 'h8000_0004));
    tbl.push_back(redir_row('h1000));
    tbl.push_back(run_row('h1004, 0, 0));
    tbl.push_back(run_row('h1008, 1, 'h1000));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(run_row('h1004, 0, 0));
    tbl.push_back(run_row('h1008, 0, 0));
    tbl.push_back(run_row('h100C, 1, 'h1004));
    tbl.push_back(redir_row('h2000));
    tbl.push_back(run_row('h2004, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 'h3000, 1, 1, 'h3000, 1, 'h2000, 1));
    tbl.push_back(run_row('h3004, 0, 0));
    tbl.push_back(run_row('h3008, 1, 'h3000));
    tbl.push_back(redir_row('h4000));
    tbl.push_back(run_row('h4004, 0, 0));
    tbl.push_back(run_row('h4008, 1, 'h4000));
    tbl.push_back(run_row('h400C, 1, 'h4004));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(run_row('h4008, 0, 0));
    tbl.push_back(run_row('h400C, 0, 0));
    tbl.push_back(run_row('h4010, 1, 'h4008));
    tbl.push_back(run_row('h4014, 1, 'h400C));
    tbl.push_back(mk(1, 'h5000, 1, 1, 1, 0, 0, 0, 0, 1, 1, 'h5000, 0, 0, 1));
    tbl.push_back(run_row('h5004, 0, 0));
    tbl.push_back(run_row('h5008, 1, 'h5000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 'h500C, 1, 'h5004, 0));
    tbl.push_back(run_row('h500C, 1, 'h5008));
    tbl.push_back(run_row('h5010, 0, 0));
    tbl.push_back(run_row('h5014, 1, 'h500C));
    tbl.push_back(redir_row(39'h7F_FFFF_FFFC));
    tbl.push_back(run_row('h0, 0, 0));
    tbl.push_back(run_row('h4, 1, 39'h7F_FFFF_FFFC));
`ifdef BP_FE_PC_GEN_RAS_EN
    tbl.push_back(redir_row('h100));
    tbl.push_back(run_row('h104, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 1, 0, 'h200, 1, 1, 'h200, 1, 'h100, 1));
    tbl.push_back(run_row('h204, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 1, 0, 'h300, 1, 1, 'h300, 1, 'h200, 1));
    tbl.push_back(run_row('h304, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 1, 0, 'h400, 1, 1, 'h400, 1, 'h300, 1));
    tbl.push_back(run_row('h404, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 'h304, 1, 'h400, 1));
    tbl.push_back(run_row('h308, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 'h204, 1, 'h304, 1));
    tbl.push_back(run_row('h208, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 'h20C, 1, 'h204, 0));
    tbl.push_back(run_row('h210, 1, 'h208));
`endif
    foreach (tbl[k]) cyc(tbl[k].i, 1'b1, tbl[k].o, $sformatf("vec%0d", k));

    for (int n = 0; n < 3000; n++) begin
      x.redir = ($urandom_range(0, 15) == 0);
      x.rpc   = va_t'({$urandom, $urandom}) & ~va_t'(3);
      x.fr    = ($urandom_range(0, 3) != 0);
      x.rv    = ($urandom_range(0, 7) != 0);
      x.miss  = ($urandom_range(0, 7) == 0);
      x.tk    = ($urandom_range(0, 5) == 0);
      x.cl    = ($urandom_range(0, 5) == 0);
      x.rt    = ($urandom_range(0, 5) == 0);
      x.tgt   = va_t'({$urandom, $urandom}) & ~va_t'(3);
      x.qr    = ($urandom_range(0, 7) != 0);
      cyc(x, 1'b0, none, $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    redirect_v = 0; queue_ready = 1; resp_v = 1; resp_miss = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("async reset fetch_v", 64'(fetch_v), 64'(0));
    chk("async reset instr_v", 64'(instr_v), 64'(0));
    chk("async reset poison", 64'(poison), 64'(0));
    #10 reset_n = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
